// File: rtl/sum_operand_recover.sv
`default_nettype none
// ============================================================================
// Module   : sum_operand_recover
// Purpose  : Recovers the unknown addend b of an adder from its known addend a,
//            its sum, carry-in and carry-out: b = {cout,sum} - a - cin.
//            The subtraction runs digit-serially, DIGIT bits per cycle, LSB
//            first. err flags inputs that no WIDTH-bit b could have produced.
// Revision : 1.0 - initial release
// ============================================================================
module sum_operand_recover #(
  parameter int WIDTH = 30,
  parameter int DIGIT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic             err
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             err_q, err_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] s_dig;
  logic [DIGIT:0]   diff;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign b         = b_q;
  assign err       = err_q;

  // Select the current digit of the captured operands and subtract with borrow;
  // diff[DIGIT] is the outgoing borrow (result went negative).
  always_comb begin
    a_dig = '0;
    s_dig = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CW'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        s_dig = sum_q[k*DIGIT +: DIGIT];
      end
    end
    diff = {1'b0, s_dig} - {1'b0, a_dig} - {{DIGIT{1'b0}}, borrow_q};
  end

  // Next-state and datapath update: capture in IDLE, one digit per RUN cycle,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    b_d      = b_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          sum_d    = sum;
          cout_d   = cout;
          cnt_d    = '0;
          borrow_d = cin;
          b_d      = '0;
          err_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NDIG; k++) begin
          if (cnt_q == CW'(k)) begin
            b_d[k*DIGIT +: DIGIT] = diff[DIGIT-1:0];
          end
        end
        borrow_d = diff[DIGIT];
        if (cnt_q == LAST_DIGIT) begin
          cnt_d   = '0;
          err_d   = cout_q ^ diff[DIGIT];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      b_q      <= b_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire
